// File: rtl/program_loader.sv
// Serial boot loader: parses SYNC/LEN/words/CSUM frames from a UART byte stream,
// writes 10-bit instruction words to imem and releases the CPU only on a good checksum.
module program_loader #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX_VALID,
    input  logic [7:0]        RX_DATA,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [9:0]        IMEM_WDATA,
    output logic              CPU_RESET,
    output logic              DONE,
    output logic              ERROR
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_LO   = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // One extra counter bit so that LEN == DEPTH never wraps to zero.
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [8:0]       DEPTH_B  = 9'(DEPTH);

    logic [2:0]       state;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       csum;
    logic [1:0]       hi_bits;
    logic [TMO_W-1:0] tmo_cnt;

    function automatic logic len_ok(input logic [7:0] len);
        return (len != 8'd0) && ({1'b0, len} <= DEPTH_B);
    endfunction

    function automatic logic hi_ok(input logic [7:0] hi);
        return hi[7:2] == 6'd0;
    endfunction

    assign cnt_next = word_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            len_q      <= '0;
            csum       <= '0;
            hi_bits    <= '0;
            tmo_cnt    <= '0;
            IMEM_WE    <= 1'b0;
            IMEM_ADDR  <= '0;
            IMEM_WDATA <= '0;
            CPU_RESET  <= 1'b1;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
        end else begin
            IMEM_WE <= 1'b0;
            DONE    <= 1'b0;

            // Inter-byte watchdog; a stalled frame is treated like any other frame error.
            if (state == ST_IDLE || RX_VALID) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_cnt   <= '0;
                state     <= ST_IDLE;
                ERROR     <= 1'b1;
                CPU_RESET <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (RX_VALID) begin
                case (state)
                    ST_IDLE: begin
                        if (RX_DATA == SYNC_BYTE) begin
                            state     <= ST_LEN;
                            ERROR     <= 1'b0;
                            CPU_RESET <= 1'b1;
                            word_cnt  <= '0;
                            csum      <= '0;
                        end
                    end
                    ST_LEN: begin
                        if (!len_ok(RX_DATA)) begin
                            state     <= ST_IDLE;
                            ERROR     <= 1'b1;
                            CPU_RESET <= 1'b1;
                        end else begin
                            len_q <= CNT_W'(RX_DATA);
                            csum  <= csum ^ RX_DATA;
                            state <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        if (!hi_ok(RX_DATA)) begin
                            state     <= ST_IDLE;
                            ERROR     <= 1'b1;
                            CPU_RESET <= 1'b1;
                        end else begin
                            hi_bits <= RX_DATA[1:0];
                            csum    <= csum ^ RX_DATA;
                            state   <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        IMEM_WE    <= 1'b1;
                        IMEM_ADDR  <= word_cnt[ADDR_W-1:0];
                        IMEM_WDATA <= {hi_bits, RX_DATA};
                        csum       <= csum ^ RX_DATA;
                        word_cnt   <= cnt_next;
                        state      <= (cnt_next == len_q) ? ST_CSUM : ST_HI;
                    end
                    ST_CSUM: begin
                        if (RX_DATA == csum) begin
                            DONE      <= 1'b1;
                            CPU_RESET <= 1'b0;
                        end else begin
                            ERROR     <= 1'b1;
                            CPU_RESET <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected imem writes are queued as frames are
// driven and matched against each IMEM_WE pulse; frame status is checked after each frame.
module tb_program_loader;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic              CLK;
    logic              RESET;
    logic              RX_VALID;
    logic [7:0]        RX_DATA;
    logic              IMEM_WE;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [9:0]        IMEM_WDATA;
    logic              CPU_RESET;
    logic              DONE;
    logic              ERROR;

    program_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RX_VALID  (RX_VALID),
        .RX_DATA   (RX_DATA),
        .IMEM_WE   (IMEM_WE),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_WDATA(IMEM_WDATA),
        .CPU_RESET (CPU_RESET),
        .DONE      (DONE),
        .ERROR     (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          we_cnt   = 0;
    logic [15:0] exp_q[$];
    logic [9:0]  fw[0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write pulse must match the oldest queued word.
    always @(negedge CLK) begin
        if (DONE === 1'b1) done_cnt++;
        if (IMEM_WE === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'({IMEM_ADDR, IMEM_WDATA}), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(IMEM_ADDR), 32'(e[15:10]));
                chk("wr_data", 32'(IMEM_WDATA), 32'(e[9:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic resync();
        @(posedge CLK);
        #1;
    endtask

    // Drive one byte for one cycle, then idle for gap cycles; gap 0 gives back-to-back strobes.
    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input int n, input int gap_max, input bit corrupt, input bit chk_sync);
        logic [7:0] cs;
        logic [7:0] hi;
        logic [7:0] lo;
        int         g;
        cs = 8'(n);
        g  = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 1));
        send_byte(8'hA5, g);
        if (chk_sync) begin
            @(negedge CLK);
            chk("sync_err_clear", 32'(ERROR), 32'd0);
            chk("sync_cpu_hold", 32'(CPU_RESET), 32'd1);
            resync();
        end
        send_byte(8'(n), g);
        for (int i = 0; i < n; i++) begin
            hi = {6'd0, fw[i][9:8]};
            lo = fw[i][7:0];
            cs = cs ^ hi ^ lo;
            exp_q.push_back({6'(i), fw[i]});
            g = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            send_byte(hi, g);
            send_byte(lo, g);
        end
        send_byte(corrupt ? (cs ^ 8'h01) : cs, 0);
    endtask

    initial begin
        int  we_before;
        bit  early_err;
        RESET    = 1'b0;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cpu_reset", 32'(CPU_RESET), 32'd1);
        chk("rst_imem_we", 32'(IMEM_WE), 32'd0);
        chk("rst_imem_addr", 32'(IMEM_ADDR), 32'd0);
        chk("rst_imem_wdata", 32'(IMEM_WDATA), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_error", 32'(ERROR), 32'd0);
        resync();
        RESET = 1'b1;
        resync();

        // Good frame: A5 02 01 23 00 45 65
        fw[0] = 10'h123;
        fw[1] = 10'h045;
        send_frame(2, 2, 1'b0, 1'b0);
        @(negedge CLK);
        chk("good_done", 32'(DONE), 32'd1);
        chk("good_cpu_release", 32'(CPU_RESET), 32'd0);
        chk("good_error", 32'(ERROR), 32'd0);
        chk("good_all_written", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        chk("good_done_one_cycle", 32'(DONE), 32'd0);
        resync();

        // Same frame with CSUM 0x64, then the good frame again
        send_frame(2, 2, 1'b1, 1'b0);
        @(negedge CLK);
        chk("badcs_done", 32'(DONE), 32'd0);
        chk("badcs_error", 32'(ERROR), 32'd1);
        chk("badcs_cpu_hold", 32'(CPU_RESET), 32'd1);
        chk("badcs_all_written", 32'(exp_q.size()), 32'd0);
        resync();
        send_frame(2, 2, 1'b0, 1'b1);
        @(negedge CLK);
        chk("reload_done", 32'(DONE), 32'd1);
        chk("reload_cpu_release", 32'(CPU_RESET), 32'd0);
        chk("reload_error", 32'(ERROR), 32'd0);
        resync();

        // Invalid LEN and HI bytes
        we_before = we_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h00, 0);
        @(negedge CLK);
        chk("len0_error", 32'(ERROR), 32'd1);
        resync();
        send_byte(8'hA5, 0);
        @(negedge CLK);
        chk("len65_sync_clear", 32'(ERROR), 32'd0);
        resync();
        send_byte(8'h41, 0);
        @(negedge CLK);
        chk("len65_error", 32'(ERROR), 32'd1);
        resync();
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h04, 0);
        @(negedge CLK);
        chk("badhi_error", 32'(ERROR), 32'd1);
        chk("badhi_cpu_hold", 32'(CPU_RESET), 32'd1);
        chk("invalid_no_writes", 32'(we_cnt - we_before), 32'd0);
        resync();

        // Idle noise followed by a fully back-to-back frame with 0xA5 as data
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 1);
        @(negedge CLK);
        chk("noise_error_kept", 32'(ERROR), 32'd1);
        chk("noise_cpu_hold", 32'(CPU_RESET), 32'd1);
        resync();
        fw[0] = 10'h2A5;
        fw[1] = 10'h1FF;
        fw[2] = 10'h0A5;
        send_frame(3, 0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("b2b_done", 32'(DONE), 32'd1);
        chk("b2b_error", 32'(ERROR), 32'd0);
        chk("b2b_all_written", 32'(exp_q.size()), 32'd0);
        resync();

        // Timeout: stall after the HI byte
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 0);
        early_err = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge CLK);
            if (ERROR === 1'b1) early_err = 1'b1;
        end
        chk("tmo_not_early", 32'(early_err), 32'd0);
        @(negedge CLK);
        chk("tmo_error_at_limit", 32'(ERROR), 32'd1);
        chk("tmo_cpu_hold", 32'(CPU_RESET), 32'd1);
        resync();
        we_before = we_cnt;
        send_byte(8'h99, 2);
        @(negedge CLK);
        chk("tmo_late_lo_ignored", 32'(we_cnt - we_before), 32'd0);
        chk("tmo_error_sticky", 32'(ERROR), 32'd1);
        resync();

        // Reset in the middle of a frame
        send_byte(8'hA5, 1);
        send_byte(8'h03, 1);
        send_byte(8'h00, 0);
        RESET = 1'b0;
        #2;
        chk("midrst_cpu_reset", 32'(CPU_RESET), 32'd1);
        chk("midrst_error", 32'(ERROR), 32'd0);
        chk("midrst_imem", 32'({IMEM_WE, IMEM_ADDR, IMEM_WDATA}), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        resync();
        fw[0] = 10'h3FF;
        fw[1] = 10'h000;
        fw[2] = 10'h155;
        send_frame(3, 1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("postrst_done", 32'(DONE), 32'd1);
        chk("postrst_cpu_release", 32'(CPU_RESET), 32'd0);
        chk("postrst_all_written", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLK);

        chk("total_done_pulses", 32'(done_cnt), 32'd4);
        chk("total_writes", 32'(we_cnt), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
